ifetch_resp: RTL and testbench

Responder for the instruction-fetch valid/ready port. It sits between the fetch unit and a synchronous 64-bit instruction RAM. It accepts one fetch request at a time and models a configurable number of wait states. It returns the addressed bytes right-justified and zero-extended, and reports alignment and decode errors on the response code.

---
 rtl/ifetch_resp.sv | 139 +++++++++++++
 tb/tb_ifetch_resp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: accepts one valid/ready fetch at a time, inserts
// wait states, reads a 64-bit synchronous RAM and returns right-justified data.
module ifetch_resp #(
   parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
   parameter int          MEM_WORDS   = 4096,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_axi_valid,
   input  logic [63:0]                  i_axi_addr,
   input  logic [1:0]                   i_axi_size,
   output logic                         o_axi_ready,
   output logic [63:0]                  o_axi_data_read,
   output logic [1:0]                   o_axi_resp,
   output logic                         o_mem_en,
   output logic [$clog2(MEM_WORDS)-1:0] o_mem_idx,
   input  logic [63:0]                  i_mem_rdata
);

   localparam int          IDX_W    = $clog2(MEM_WORDS);
   localparam logic [64:0] ADDR_END = {1'b0, ADDR_BASE} + (65'(MEM_WORDS) << 3);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

   state_t           state, state_next;
   logic [3:0]       wcnt;
   logic [1:0]       size_q;
   logic [2:0]       byte_q;
   logic [IDX_W-1:0] idx_q;
   logic [1:0]       resp_q;

   logic             accept;
   logic             misaligned;
   logic             out_of_range;
   logic [1:0]       resp_next;
   logic [63:0]      shifted;
   logic [63:0]      masked;

   assign accept = (state == S_IDLE) && i_axi_valid;

   // Error classification is done on the live request and frozen at accept,
   // so later changes on the request bus cannot alter the response.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case can leave it unassigned and infer a latch.
      misaligned = 1'b0;
      unique case (i_axi_size)
         2'd0: misaligned = 1'b0;
         2'd1: misaligned = i_axi_addr[0];
         2'd2: misaligned = |i_axi_addr[1:0];
         2'd3: misaligned = |i_axi_addr[2:0];
      endcase
   end

   assign out_of_range = ({1'b0, i_axi_addr} < {1'b0, ADDR_BASE}) ||
                         ({1'b0, i_axi_addr} >= ADDR_END);

   assign resp_next = out_of_range ? RESP_DECERR :
                      misaligned   ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: if (i_axi_valid) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_READ;
         S_WAIT: if (wcnt == 4'd1) state_next = S_READ;
         S_READ: state_next = S_RESP;
         S_RESP: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wcnt   <= '0;
         size_q <= '0;
         byte_q <= '0;
         idx_q  <= '0;
         resp_q <= RESP_OKAY;
      end else begin
         if (accept) begin
            wcnt   <= 4'(WAIT_CYCLES);
            size_q <= i_axi_size;
            byte_q <= i_axi_addr[2:0];
            idx_q  <= IDX_W'((i_axi_addr - ADDR_BASE) >> 3);
            resp_q <= resp_next;
         end else if (state == S_WAIT) begin
            wcnt <= wcnt - 4'd1;
         end
      end
   end

   // RAM data arrives in RESP; align the addressed lane to bit 0, then
   // zero everything above the transfer size.
   assign shifted = i_mem_rdata >> {byte_q, 3'b000};

   always_comb begin
      masked = '0;
      unique case (size_q)
         2'd0: masked = {56'd0, shifted[7:0]};
         2'd1: masked = {48'd0, shifted[15:0]};
         2'd2: masked = {32'd0, shifted[31:0]};
         2'd3: masked = shifted;
      endcase
   end

   always_comb begin
      o_axi_ready     = 1'b0;
      o_axi_resp      = RESP_OKAY;
      o_axi_data_read = '0;
      o_mem_en        = 1'b0;
      if (state == S_READ) begin
         o_mem_en = (resp_q == RESP_OKAY);
      end
      if (state == S_RESP) begin
         o_axi_ready = 1'b1;
         o_axi_resp  = resp_q;
         if (resp_q == RESP_OKAY) begin
            o_axi_data_read = masked;
         end
      end
   end

   assign o_mem_idx = idx_q;

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp: latency, data alignment, error codes,
// back-to-back throughput and reset abort, against a small RAM model.
`timescale 1ns/1ps
module tb_ifetch_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [63:0] addr;
   logic [1:0]  size;
   logic        ready;
   logic [63:0] data;
   logic [1:0]  resp;
   logic        mem_en;
   logic [11:0] mem_idx;
   logic [63:0] mem_rdata = 64'd0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ifetch_resp #(
      .ADDR_BASE  (64'h8000_0000),
      .MEM_WORDS  (4096),
      .WAIT_CYCLES(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_axi_valid    (valid),
      .i_axi_addr     (addr),
      .i_axi_size     (size),
      .o_axi_ready    (ready),
      .o_axi_data_read(data),
      .o_axi_resp     (resp),
      .o_mem_en       (mem_en),
      .o_mem_idx      (mem_idx),
      .i_mem_rdata    (mem_rdata)
   );

   logic [63:0] ram [0:7];
   initial begin
      ram[0] = 64'h1111_2222_3333_4444;
      ram[1] = 64'h5555_6666_7777_8888;
      ram[2] = 64'h9999_AAAA_BBBB_CCCC;
      ram[3] = 64'h0;
      ram[4] = 64'h0;
      ram[5] = 64'h0;
      ram[6] = 64'h0;
      ram[7] = 64'hDEAD_BEEF_0123_4567;
   end

   always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_idx[2:0]];

   int          en_cnt    = 0;
   int          dbl_ready = 0;
   logic        ready_d   = 1'b0;
   logic [11:0] last_idx  = 12'd0;

   always @(posedge clk) begin
      if (mem_en) begin
         en_cnt   <= en_cnt + 1;
         last_idx <= mem_idx;
      end
      ready_d <= ready;
      if (ready && ready_d) dbl_ready <= dbl_ready + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a request and waits (bounded) for the ready pulse; valid stays high.
   task automatic fetch(input logic [63:0] a, input logic [1:0] s,
                        output int cyc, output logic [63:0] d, output logic [1:0] r);
      addr  = a;
      size  = s;
      valid = 1'b1;
      cyc   = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!ready && cyc < 40);
      d = data;
      r = resp;
   endtask

   task automatic idle();
      valid = 1'b0;
      @(posedge clk); #1;
   endtask

   int          cyc;
   int          en0;
   int          seen;
   logic [63:0] d;
   logic [1:0]  r;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      addr  = 64'd0;
      size  = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_data", data, 64'd0);
      check("rst_resp", 64'(resp), 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_mem_idx", 64'(mem_idx), 64'd0);
      rst = 1'b0;

      fetch(64'h8000_0000, 2'd2, cyc, d, r);
      check("w0_lat", 64'(cyc), 64'd4);
      check("w0_data", d, 64'h3333_4444);
      check("w0_resp", 64'(r), 64'd0);
      idle();

      fetch(64'h8000_0004, 2'd2, cyc, d, r);
      check("w4_lat", 64'(cyc), 64'd4);
      check("w4_data", d, 64'h1111_2222);
      check("w4_resp", 64'(r), 64'd0);
      idle();

      // Back-to-back with valid held high: 5 cycles between ready pulses.
      fetch(64'h8000_0000, 2'd2, cyc, d, r);
      check("b2b0_lat", 64'(cyc), 64'd4);
      check("b2b0_data", d, 64'h3333_4444);
      fetch(64'h8000_0004, 2'd2, cyc, d, r);
      check("b2b1_gap", 64'(cyc), 64'd5);
      check("b2b1_data", d, 64'h1111_2222);
      fetch(64'h8000_0008, 2'd2, cyc, d, r);
      check("b2b2_gap", 64'(cyc), 64'd5);
      check("b2b2_data", d, 64'h7777_8888);
      check("b2b2_idx", 64'(last_idx), 64'd1);
      idle();

      en0 = en_cnt;
      fetch(64'h8000_0002, 2'd2, cyc, d, r);
      check("slv_lat", 64'(cyc), 64'd4);
      check("slv_resp", 64'(r), 64'd2);
      check("slv_data", d, 64'd0);
      idle();
      check("slv_no_mem_en", 64'(en_cnt - en0), 64'd0);

      en0 = en_cnt;
      fetch(64'h7FFF_FFFC, 2'd2, cyc, d, r);
      check("dec_low_resp", 64'(r), 64'd3);
      check("dec_low_data", d, 64'd0);
      idle();
      fetch(64'h8000_8000, 2'd2, cyc, d, r);
      check("dec_end_resp", 64'(r), 64'd3);
      check("dec_end_data", d, 64'd0);
      idle();
      fetch(64'h7FFF_FFFE, 2'd2, cyc, d, r);
      check("dec_both_resp", 64'(r), 64'd3);
      idle();
      check("dec_no_mem_en", 64'(en_cnt - en0), 64'd0);

      fetch(64'h8000_7FF8, 2'd3, cyc, d, r);
      check("last_resp", 64'(r), 64'd0);
      check("last_data", d, 64'hDEAD_BEEF_0123_4567);
      check("last_idx", 64'(last_idx), 64'hFFF);
      idle();

      fetch(64'h8000_0003, 2'd0, cyc, d, r);
      check("byte_data", d, 64'h33);
      idle();
      fetch(64'h8000_0006, 2'd1, cyc, d, r);
      check("half_data", d, 64'h1111);
      idle();
      fetch(64'h8000_0008, 2'd3, cyc, d, r);
      check("dword_data", d, 64'h5555_6666_7777_8888);
      idle();

      // Request bus changes after accept must not affect the transaction.
      addr  = 64'h8000_0004;
      size  = 2'd2;
      valid = 1'b1;
      @(posedge clk); #1;
      addr = 64'h8000_0002;
      size = 2'd3;
      cyc  = 1;
      while (!ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("hold_lat", 64'(cyc), 64'd4);
      check("hold_data", data, 64'h1111_2222);
      check("hold_resp", 64'(resp), 64'd0);
      idle();

      // Valid dropping after accept still completes the transaction.
      addr  = 64'h8000_0010;
      size  = 2'd3;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      cyc   = 1;
      while (!ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("drop_lat", 64'(cyc), 64'd4);
      check("drop_data", data, 64'h9999_AAAA_BBBB_CCCC);
      idle();

      // Reset while in WAIT discards the request.
      en0   = en_cnt;
      addr  = 64'h8000_0000;
      size  = 2'd2;
      valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst   = 1'b1;
      valid = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 0;
      repeat (6) begin
         if (ready) seen++;
         @(posedge clk); #1;
      end
      check("rstwait_no_ready", 64'(seen), 64'd0);
      check("rstwait_no_mem_en", 64'(en_cnt - en0), 64'd0);

      fetch(64'h8000_0000, 2'd2, cyc, d, r);
      check("after_rst_lat", 64'(cyc), 64'd4);
      check("after_rst_data", d, 64'h3333_4444);
      idle();

      check("ready_single_cycle", 64'(dbl_ready), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
